// File: rtl/mmul_fifo_loader_if.sv
// Word-wide pipelined memory read port between the loader and its memory.
// Only one read is ever outstanding at a time.
interface mmul_fifo_loader_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_W     = 64
);
    logic                  mem_read;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_waitrequest;
    logic [WORD_W-1:0]     mem_readdata;
    logic                  mem_readdatavalid;

    modport master (
        output mem_read, mem_addr,
        input  mem_waitrequest, mem_readdata, mem_readdatavalid
    );
    modport slave (
        input  mem_read, mem_addr,
        output mem_waitrequest, mem_readdata, mem_readdatavalid
    );
endinterface

// File: rtl/mmul_fifo_loader.sv
// Fetches B and the M rows of A for one matrix-vector job and unpacks them into FIFOs.
// Optional stall counter on o_stall_cycles enabled by defining MMUL_LOADER_PERF_EN.
module mmul_fifo_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 8,
    parameter int M          = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    output logic                  o_busy,
    output logic                  o_done,
    mmul_fifo_loader_if.master    mem,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic                  o_b_wren,
    input  logic                  i_b_full,
    output logic                  o_a_wren [M],
    input  logic                  i_a_full [M],
    output logic                  o_mmul_clr,
    output logic                  o_mmul_en,
    output logic [31:0]           o_stall_cycles
);
    localparam int WORD_BYTES = N*DATA_WIDTH/8;
    localparam int WORD_W     = N*DATA_WIDTH;
    localparam int KW         = $clog2(N+1);
    localparam int TW         = $clog2(M+2);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_REQ, S_WAIT, S_UNPACK, S_START, S_DONE
    } state_t;

    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [TW-1:0]         r_t;
    logic [KW-1:0]         r_k;
    logic [WORD_W-1:0]     r_word;
    logic                  w_rd, w_wr, w_tgt_full;

    // Target 0 is the B FIFO, target t>0 is A row t-1.
    always_comb begin
        w_tgt_full = i_b_full;
        for (int i = 0; i < M; i++)
            if (r_t == TW'(i+1)) w_tgt_full = i_a_full[i];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_rd       = 1'b0;
        w_wr       = 1'b0;
        o_mmul_clr = 1'b0;
        o_mmul_en  = 1'b0;
        o_done     = 1'b0;
        case (r_state)
            S_IDLE:   if (i_start) w_next = S_CLR;
            S_CLR: begin
                o_mmul_clr = 1'b1;
                w_next     = S_REQ;
            end
            S_REQ: begin
                w_rd = 1'b1;
                if (!mem.mem_waitrequest) w_next = S_WAIT;
            end
            S_WAIT:   if (mem.mem_readdatavalid) w_next = S_UNPACK;
            S_UNPACK: if (!w_tgt_full) begin
                w_wr = 1'b1;
                if (r_k == KW'(N-1)) w_next = (r_t == TW'(M)) ? S_START : S_REQ;
            end
            S_START: begin
                o_mmul_en = 1'b1;
                w_next    = S_DONE;
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default:  w_next = S_IDLE;
        endcase
    end

    // Word is consumed LSB-first by shifting, so the current element is always the low slice.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_base <= '0;
            r_t    <= '0;
            r_k    <= '0;
            r_word <= '0;
        end else begin
            case (r_state)
                S_IDLE:   if (i_start) r_base <= i_base_addr;
                S_CLR: begin
                    r_t <= '0;
                    r_k <= '0;
                end
                S_WAIT:   if (mem.mem_readdatavalid) begin
                    r_word <= mem.mem_readdata;
                    r_k    <= '0;
                end
                S_UNPACK: if (w_wr) begin
                    r_word <= r_word >> DATA_WIDTH;
                    if (r_k == KW'(N-1)) r_t <= r_t + 1'b1;
                    else                 r_k <= r_k + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_busy       = (r_state != S_IDLE);
    assign mem.mem_read = w_rd;
    assign mem.mem_addr = w_rd ? r_base + ADDR_WIDTH'(r_t) * ADDR_WIDTH'(WORD_BYTES) : '0;
    assign o_wdata      = r_word[DATA_WIDTH-1:0];
    assign o_b_wren     = w_wr && (r_t == '0);

    always_comb begin
        for (int i = 0; i < M; i++)
            o_a_wren[i] = w_wr && (r_t == TW'(i+1));
    end

`ifdef MMUL_LOADER_PERF_EN
    logic [31:0] r_stall;
    logic        w_stall;

    assign w_stall = ((r_state == S_REQ) && mem.mem_waitrequest) ||
                     ((r_state == S_UNPACK) && w_tgt_full);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                            r_stall <= '0;
        else if (r_state == S_IDLE && i_start)   r_stall <= '0;
        else if (w_stall && (r_stall != '1))     r_stall <= r_stall + 1'b1;
    end

    assign o_stall_cycles = r_stall;
`else
    assign o_stall_cycles = '0;
`endif
endmodule

// File: tb/tb_mmul_fifo_loader.sv
// Scoreboard bench: jobs push expected reads/writes/pulses, a negedge monitor pops and compares.
module tb_mmul_fifo_loader;
    localparam int DW = 8;
    localparam int N  = 8;
    localparam int M  = 8;
    localparam int AW = 32;
    localparam int WB = N*DW/8;
    localparam int WW = N*DW;

    typedef struct { int tgt; logic [DW-1:0] d; } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          busy, done, b_wren, clr, en;
    logic [DW-1:0] wdata;
    logic [31:0]   stall;
    logic          b_full = 1'b0;
    logic          a_wren [M];
    logic          a_full [M];

    mmul_fifo_loader_if #(.ADDR_WIDTH(AW), .WORD_W(WW)) mif ();

    mmul_fifo_loader #(.DATA_WIDTH(DW), .N(N), .M(M), .ADDR_WIDTH(AW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_base_addr(base_addr),
        .o_busy(busy), .o_done(done), .mem(mif), .o_wdata(wdata),
        .o_b_wren(b_wren), .i_b_full(b_full), .o_a_wren(a_wren), .i_a_full(a_full),
        .o_mmul_clr(clr), .o_mmul_en(en), .o_stall_cycles(stall)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] exp_rd[$];
    wr_t           exp_wr[$];
    int            hold_log[$];
    logic [WW-1:0] mem [logic [AW-1:0]];
    int pend_clr = 0, pend_en = 0, pend_done = 0, exp_len = -1, start_cyc = 0;
    int last_tgt = -1, tgt_cnt = 0, jrd = 0, hold = 0, holds = 0, done_cnt = 0;
    int force_wr = 0, full_cnt = 0;
    bit exp_busy = 0, rand_mode = 0, arm_full = 0, inject_rdv = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic tgt_full(input int t);
        if (t == 0) return b_full;
        if (t >= 1 && t <= M) return a_full[t-1];
        return 1'b0;
    endfunction

    // Memory and FIFO-full responder: outputs change 1 time unit after the rising edge.
    initial begin
        bit            s_acc, s_wait, pend;
        logic [AW-1:0] s_addr, pend_addr;
        int            lat;
        pend = 0; lat = 0; pend_addr = '0;
        mif.mem_waitrequest = 1'b0; mif.mem_readdatavalid = 1'b0; mif.mem_readdata = '0;
        for (int r = 0; r < M; r++) a_full[r] = 1'b0;
        forever begin
            @(negedge clk);
            s_acc  = mif.mem_read && !mif.mem_waitrequest;
            s_wait = mif.mem_read && mif.mem_waitrequest;
            s_addr = mif.mem_addr;
            @(posedge clk); #1;
            mif.mem_readdatavalid = 1'b0;
            if (s_acc) begin
                pend = 1; pend_addr = s_addr;
                lat = rand_mode ? int'($urandom_range(0, 3)) : 0;
            end
            if (pend) begin
                if (lat == 0) begin
                    mif.mem_readdatavalid = 1'b1;
                    mif.mem_readdata = mem.exists(pend_addr) ? mem[pend_addr] : '0;
                    pend = 0;
                end else lat--;
            end
            if (inject_rdv) begin
                mif.mem_readdatavalid = 1'b1;
                mif.mem_readdata = {$urandom, $urandom};
                inject_rdv = 0;
            end
            if (s_wait && force_wr > 0) force_wr--;
            mif.mem_waitrequest = (force_wr > 0) || (rand_mode && $urandom_range(0, 3) == 0);
            if (full_cnt > 0) full_cnt--;
            if (full_cnt == 0 && arm_full && last_tgt == 4 && tgt_cnt == 2) begin
                full_cnt = 5; arm_full = 0;
            end
            b_full = rand_mode && ($urandom_range(0, 4) == 0);
            for (int r = 0; r < M; r++)
                a_full[r] = (r == 3 && full_cnt > 0) || (rand_mode && $urandom_range(0, 5) == 0);
        end
    end

    task automatic monitor_cycle();
        int  nb, tgt;
        wr_t e;
        bit  nxt;
        nb = 0; tgt = -1;
        chk("busy", busy, exp_busy);
        if (b_wren) begin nb++; tgt = 0; end
        for (int r = 0; r < M; r++) if (a_wren[r]) begin nb++; tgt = r + 1; end
        if (nb > 1) chk("one_wren", nb, 1);
        if (nb >= 1) begin
            if (exp_wr.size() == 0) chk("unexpected_wr", nb, 0);
            else begin
                e = exp_wr.pop_front();
                chk("wr_tgt", tgt, e.tgt);
                chk("wr_data", wdata, e.d);
                chk("wr_while_full", tgt_full(tgt), 0);
                if (tgt == last_tgt) tgt_cnt++;
                else begin last_tgt = tgt; tgt_cnt = 1; end
            end
        end else if (exp_wr.size() > 0 && exp_wr[0].tgt == last_tgt) begin
            chk("idle_only_when_full", tgt_full(last_tgt), 1);
            chk("hold_wdata", wdata, exp_wr[0].d);
            holds++;
        end
        if (mif.mem_read) begin
            if (exp_rd.size() == 0) chk("unexpected_rd", mif.mem_addr, 0);
            else begin
                chk("rd_addr", mif.mem_addr, exp_rd[0]);
                hold++;
                if (!mif.mem_waitrequest) begin
                    void'(exp_rd.pop_front());
                    hold_log.push_back(hold);
                    hold = 0; jrd++;
                end
            end
        end
        if (clr) begin
            chk("clr_pending", pend_clr, 1);
            chk("clr_before_read", jrd, 0);
            pend_clr--;
        end
        if (en) begin
            chk("en_pending", pend_en, 1);
            chk("en_after_writes", exp_wr.size(), 0);
            pend_en--;
        end
        if (done) begin
            chk("done_pending", pend_done, 1);
            chk("done_after_en", pend_en, 0);
            chk("done_all_reads", exp_rd.size(), 0);
            if (exp_len > 0) chk("job_len", cyc - start_cyc, exp_len);
            pend_done--; done_cnt++;
        end
        if (start && !busy) start_cyc = cyc;
        nxt = exp_busy;
        if (start && !exp_busy) nxt = 1;
        else if (done)          nxt = 0;
        exp_busy = nxt;
    endtask

    initial forever begin
        @(negedge clk);
        if (rst_n) monitor_cycle();
    end

    task automatic pulse_start(input logic [AW-1:0] b);
        @(posedge clk); #1;
        base_addr = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic issue_job(input logic [AW-1:0] b, input bit fixed_w0, input int len);
        logic [WW-1:0] w;
        logic [AW-1:0] a;
        for (int t = 0; t <= M; t++) begin
            a = b + AW'(t*WB);
            w = {$urandom, $urandom};
            if (fixed_w0 && t == 0) w = 64'h0807060504030201;
            mem[a] = w;
            exp_rd.push_back(a);
            for (int k = 0; k < N; k++) exp_wr.push_back('{tgt: t, d: w[k*DW +: DW]});
        end
        pend_clr = 1; pend_en = 1; pend_done = 1; exp_len = len;
        last_tgt = -1; tgt_cnt = 0; jrd = 0; hold = 0; holds = 0; done_cnt = 0;
        hold_log.delete();
        pulse_start(b);
    endtask

    task automatic wait_job(input int exp_stall);
        int n;
        n = 0;
        while (pend_done != 0 && n < 3000) begin @(negedge clk); n++; end
        chk("job_timeout", pend_done, 0);
        repeat (3) @(negedge clk);
        chk("rd_left", exp_rd.size(), 0);
        chk("wr_left", exp_wr.size(), 0);
        if (exp_stall >= 0) begin
`ifdef MMUL_LOADER_PERF_EN
            chk("stall_cycles", stall, exp_stall);
`else
            chk("stall_cycles", stall, 0);
`endif
        end
    endtask

    task automatic check_idle_outputs();
        chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
        chk("rst_read", mif.mem_read, 0); chk("rst_addr", mif.mem_addr, 0);
        chk("rst_wdata", wdata, 0); chk("rst_b_wren", b_wren, 0);
        for (int r = 0; r < M; r++) chk("rst_a_wren", a_wren[r], 0);
        chk("rst_clr", clr, 0); chk("rst_en", en, 0); chk("rst_stall", stall, 0);
    endtask

    initial begin
        int n;
        #2 check_idle_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Zero-wait job with a known B word; 93 cycles, one cycle per read.
        issue_job(32'h1000, 1, 93);
        wait_job(0);
        chk("n_reads", jrd, 9);
        foreach (hold_log[i]) chk("rd_hold_1", hold_log[i], 1);

        // Row 3 full for 5 cycles at element 2.
        arm_full = 1;
        issue_job(32'h1000, 0, 98);
        wait_job(5);
        chk("full_hold_cycles", holds, 5);

        // First read held off by 4 wait cycles.
        @(negedge clk);
        force_wr = 4; mif.mem_waitrequest = 1'b1;
        issue_job(32'h1000, 0, 97);
        wait_job(4);
        chk("n_reads_wait", jrd, 9);
        if (hold_log.size() > 0) chk("first_rd_hold", hold_log[0], 5);
        else chk("first_rd_hold_missing", hold_log.size(), 1);

        // Second start mid-job must be ignored.
        issue_job(32'h2000, 0, 93);
        repeat (20) @(posedge clk);
        pulse_start(32'h3000);
        wait_job(0);
        repeat (20) @(negedge clk);
        chk("single_done", done_cnt, 1);

        // Reset during UNPACK of row 2, then a stray readdatavalid, then a clean job.
        issue_job(32'h4000, 0, -1);
        n = 0;
        while (!(last_tgt == 3 && tgt_cnt >= 3) && n < 500) begin @(negedge clk); n++; end
        chk("reset_trigger_timeout", n < 500, 1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1 check_idle_outputs();
        exp_rd.delete(); exp_wr.delete();
        pend_clr = 0; pend_en = 0; pend_done = 0; exp_busy = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        inject_rdv = 1;
        repeat (5) @(negedge clk);
        chk("idle_after_reset", busy, 0);
        issue_job(32'h5000, 0, 93);
        wait_job(0);

        // Randomized memory latency, waitrequest and FIFO backpressure.
        rand_mode = 1;
        for (int j = 0; j < 6; j++) begin
            issue_job($urandom & 32'h0FFF_FFF8, 0, -1);
            wait_job(-1);
            chk("rand_single_done", done_cnt, 1);
        end
        rand_mode = 0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mmul_fifo_loader.md
Name: mmul_fifo_loader

Overview:
Upstream stage of the matrix-vector multiplier. On a start pulse it clears the multiplier and fetches the B vector and the M rows of A from a word-wide memory read port. It unpacks each word into N elements, writes them into the B FIFO and the per-row A FIFOs, then pulses the multiplier enable. One B vector plus one M x N A matrix is loaded per job.

Parameters:
DATA_WIDTH, 8, element width in bits; must be a multiple of 8.
N, 8, elements per row, which is also the B vector length and the elements per memory word.
M, 8, number of A rows and A FIFOs.
ADDR_WIDTH, 32, memory byte-address width.
(localparam WORD_BYTES = N*DATA_WIDTH/8; word width is N*DATA_WIDTH.)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  one-cycle job request; honoured only when idle
i_base_addr  in  ADDR_WIDTH  byte address of B word; sampled when i_start is accepted
o_busy  out  1  high from the cycle after acceptance until o_done
o_done  out  1  one-cycle pulse at job completion
o_mem_read  out  1  read request
o_mem_addr  out  ADDR_WIDTH  read byte address
i_mem_waitrequest  in  1  high = request not accepted
i_mem_readdata  in  N*DATA_WIDTH  returned word
i_mem_readdatavalid  in  1  returned word valid
o_wdata  out  DATA_WIDTH  element shared by all FIFO write ports
o_b_wren  out  1  B FIFO write
i_b_full  in  1  B FIFO full
o_a_wren  out  M (unpacked array [M])  per-row A FIFO write
i_a_full  in  M (unpacked array [M])  per-row A FIFO full
o_mmul_clr  out  1  one-cycle clear to the multiplier
o_mmul_en  out  1  one-cycle start to the multiplier
o_stall_cycles  out  32  stall counter (see Optional Feature)

Behaviour:
- Reset: FSM goes to IDLE. All outputs are 0: o_mem_addr, o_wdata and o_stall_cycles are 0, and all write enables and pulses are low. Reset mid-job abandons the job. A late readdatavalid after reset is ignored.
- Memory layout: target t=0 is B at base. Target t=1..M is A row t-1 at base + t*WORD_BYTES. Targets are fetched strictly in order 0..M. Exactly one read is outstanding at a time.
- FSM states:
  - IDLE: i_start moves to CLR and latches the base. A start while not IDLE is ignored.
  - CLR: o_mmul_clr=1 for one cycle; target counter=0. Next state is REQ.
  - REQ: o_mem_read=1 and o_mem_addr held stable while i_mem_waitrequest=1. Move to WAIT on the first cycle with waitrequest=0.
  - WAIT: o_mem_read=0. On i_mem_readdatavalid, latch the word into the shift register and move to UNPACK. readdatavalid outside WAIT is ignored.
  - UNPACK: element k (0..N-1) is word bits [k*DATA_WIDTH +: DATA_WIDTH], so element 0 (LSB) is written first.
    - Each cycle, if the target FIFO is not full, assert its wren with o_wdata = element k and advance k.
    - If the target FIFO is full, wren=0, and o_wdata and k hold.
    - Only the current target's wren may be high; at most one wren is high per cycle.
    - After element N-1: if t<M, t++ and go to REQ; else go to START.
  - START: o_mmul_en=1 for one cycle, then DONE.
  - DONE: o_done=1 for one cycle, then IDLE.
- o_busy=1 in every state except IDLE.
- Minimum job length with zero-wait memory (readdatavalid the cycle after acceptance, no full FIFOs): 1 (CLR) + (M+1)*(2+N) + 2 cycles. That is 93 cycles for M=N=8, from the cycle after i_start to o_done inclusive.
- The counters are sized $clog2(N+1) for k and $clog2(M+2) for t. No wrap occurs within a job.

Optional Feature:
MMUL_LOADER_PERF_EN
- Defined: o_stall_cycles counts cycles in REQ with waitrequest=1 plus cycles in UNPACK with the target FIFO full. It clears to 0 on i_start acceptance, holds its value after o_done, and saturates at 2^32-1.
- Undefined: o_stall_cycles is tied to 0 and no counter logic is generated.

Test Plan:
1. M=N=8, base 0x1000, zero-wait memory, no full -> reads at 0x1000, 0x1008, ..., 0x1040 (9 reads); B receives elements 0..7 of word 0, LSB first; row r FIFO receives word r+1; one o_mmul_clr before the first read; one o_mmul_en after the final write; o_done 93 cycles after start.
2. Word 0 = 0x0807060504030201 -> o_b_wren writes 0x01, 0x02, ..., 0x08 in order on consecutive cycles.
3. i_a_full[3] high for 5 cycles during row 3 element 2 -> o_a_wren[3] low for exactly those 5 cycles with o_wdata held; no duplicate or lost element; job is 5 cycles longer; stall counter = 5 (PERF_EN).
4. i_mem_waitrequest high for 4 cycles on the first read -> o_mem_read and o_mem_addr=0x1000 held stable 5 cycles; only one read is issued.
5. i_start pulsed again mid-job -> ignored; exactly one o_done; base address unchanged.
6. i_rst_n asserted during UNPACK of row 2 -> all outputs are 0 immediately; a subsequent i_start runs a full clean job from B.
